// File: rtl/fp_add_sequencer.sv
// Multi-cycle IEEE-754 adder/subtractor: one operation walks UNPACK, ALIGN, ADD,
// NORM and PACK, then holds its result in DONE until the consumer takes it.
module fp_add_sequencer #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   flag_ovf,
    output logic                   flag_inv,
    output logic                   busy
);
    localparam int W   = EXP_W + MAN_W + 1;
    localparam int M   = MAN_W + 1;
    localparam int XW  = EXP_W + 2;
    localparam int LZW = $clog2(M + 1);
    localparam logic [EXP_W-1:0] EMAX   = '1;
    localparam logic [EXP_W-1:0] SH_LIM = EXP_W'(M + 2);
    localparam logic [W-1:0]     QNAN   = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, PACK, DONE} state_t;

    state_t             state_q;
    logic               sa_q, sb_q, sign_q, eff_sub_q, zero_q, special_q, spec_inv_q;
    logic [EXP_W-1:0]   ea_q, eb_q;
    logic [MAN_W-1:0]   fa_q, fb_q, man_q;
    logic [M-1:0]       ma_q, mb_q, mbig_q, msm_q;
    logic               nan_a_q, nan_b_q, inf_a_q, inf_b_q;
    logic [XW-1:0]      exp_q;
    logic [M:0]         sum_q;
    logic [W-1:0]       spec_res_q, result_q;
    logic               in_ready_q, out_valid_q, ovf_q, inv_q, busy_q;

    function automatic logic [LZW-1:0] clz(input logic [M-1:0] v);
        clz = LZW'(M);
        for (int i = 0; i < M; i++)
            if (v[i]) clz = LZW'(M - 1 - i);
    endfunction

    logic             a_ge_b;
    logic [EXP_W-1:0] diff;
    logic [M-1:0]     msm_raw, msm_sh;
    logic [LZW-1:0]   lz;
    logic [MAN_W-1:0] man_sh;

    always_comb begin
        a_ge_b  = {ea_q, ma_q} >= {eb_q, mb_q};
        diff    = a_ge_b ? (ea_q - eb_q) : (eb_q - ea_q);
        msm_raw = a_ge_b ? mb_q : ma_q;
        msm_sh  = (diff >= SH_LIM) ? '0 : (msm_raw >> diff);
        lz      = clz(sum_q[M-1:0]);
        man_sh  = MAN_W'(sum_q[M-1:0] << lz);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            {sa_q, sb_q, sign_q, eff_sub_q, zero_q, special_q, spec_inv_q} <= '0;
            {ea_q, eb_q, fa_q, fb_q, man_q} <= '0;
            {ma_q, mb_q, mbig_q, msm_q} <= '0;
            {nan_a_q, nan_b_q, inf_a_q, inf_b_q} <= '0;
            exp_q       <= '0;
            sum_q       <= '0;
            spec_res_q  <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            inv_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    sa_q <= a[W-1];  ea_q <= a[W-2:MAN_W]; fa_q <= a[MAN_W-1:0];
                    sb_q <= b[W-1] ^ sub; eb_q <= b[W-2:MAN_W]; fb_q <= b[MAN_W-1:0];
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                    state_q    <= UNPACK;
                end
                UNPACK: begin
                    // Denormals (exp=0) get no hidden bit and a zero mantissa.
                    ma_q    <= (ea_q != '0) ? {1'b1, fa_q} : '0;
                    mb_q    <= (eb_q != '0) ? {1'b1, fb_q} : '0;
                    nan_a_q <= (ea_q == EMAX) && (fa_q != '0);
                    nan_b_q <= (eb_q == EMAX) && (fb_q != '0);
                    inf_a_q <= (ea_q == EMAX) && (fa_q == '0);
                    inf_b_q <= (eb_q == EMAX) && (fb_q == '0);
                    zero_q  <= 1'b0;
                    state_q <= ALIGN;
                end
                ALIGN: begin
                    special_q  <= 1'b1;
                    spec_inv_q <= 1'b0;
                    if (nan_a_q || nan_b_q || (inf_a_q && inf_b_q && (sa_q != sb_q))) begin
                        spec_res_q <= QNAN;
                        spec_inv_q <= 1'b1;
                    end else if (inf_a_q) begin
                        spec_res_q <= {sa_q, EMAX, {MAN_W{1'b0}}};
                    end else if (inf_b_q) begin
                        spec_res_q <= {sb_q, EMAX, {MAN_W{1'b0}}};
                    end else if (ma_q == '0 && mb_q == '0) begin
                        spec_res_q <= {sa_q & sb_q, {(W-1){1'b0}}};
                    end else begin
                        special_q <= 1'b0;
                    end
                    sign_q    <= a_ge_b ? sa_q : sb_q;
                    exp_q     <= {2'b00, a_ge_b ? ea_q : eb_q};
                    mbig_q    <= a_ge_b ? ma_q : mb_q;
                    msm_q     <= msm_sh;
                    eff_sub_q <= sa_q ^ sb_q;
                    state_q   <= ADD;
                end
                ADD: begin
                    sum_q   <= eff_sub_q ? ({1'b0, mbig_q} - {1'b0, msm_q})
                                         : ({1'b0, mbig_q} + {1'b0, msm_q});
                    state_q <= NORM;
                end
                NORM: begin
                    if (sum_q[M]) begin
                        man_q <= sum_q[MAN_W:1];
                        exp_q <= exp_q + XW'(1);
                    end else if (sum_q == '0) begin
                        zero_q <= 1'b1;
                        sign_q <= 1'b0;
                    end else if (exp_q <= XW'(lz)) begin
                        zero_q <= 1'b1;
                    end else begin
                        man_q <= man_sh;
                        exp_q <= exp_q - XW'(lz);
                    end
                    state_q <= PACK;
                end
                PACK: begin
                    ovf_q <= 1'b0;
                    inv_q <= 1'b0;
                    if (special_q) begin
                        result_q <= spec_res_q;
                        inv_q    <= spec_inv_q;
                    end else if (zero_q) begin
                        result_q <= {sign_q, {(W-1){1'b0}}};
                    end else if (exp_q >= {2'b00, EMAX}) begin
                        result_q <= {sign_q, EMAX, {MAN_W{1'b0}}};
                        ovf_q    <= 1'b1;
                    end else begin
                        result_q <= {sign_q, exp_q[EXP_W-1:0], man_q};
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_ovf  = ovf_q;
    assign flag_inv  = inv_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed bench for fp_add_sequencer: hand-computed single-precision vectors,
// latency, backpressure, specials and mid-operation reset.
module tb_fp_add_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, sub, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic        flag_ovf, flag_inv, busy;

    int checks = 0;
    int errors = 0;

    fp_add_sequencer #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_ovf(flag_ovf), .flag_inv(flag_inv), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stimulus only: accept one operation, count cycles to out_valid, then consume.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                          output logic [31:0] res, output logic ovf, output logic inv,
                          output int lat);
        a = ia; b = ib; sub = isub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = n; break; end
        end
        res = result; ovf = flag_ovf; inv = flag_inv;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({in_ready, out_valid, busy, flag_ovf, flag_inv} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 10000", {in_ready, out_valid, busy, flag_ovf, flag_inv});
        end
        checks++;
        if (result !== 32'h0) begin
            errors++; $display("FAIL reset_result got %h want 00000000", result);
        end
    endtask

    task automatic test_arith();
        logic [31:0] vec_a [11], vec_b [11], vec_r [11];
        logic        vec_s [11];
        logic [31:0] r; logic o, v; int lat;
        vec_a = '{32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                  32'h3F800000, 32'h3F800000, 32'h80000000, 32'h80000000, 32'h00800001, 32'h80800001};
        vec_b = '{32'h3F800000, 32'h3FA00000, 32'h3F800000, 32'h40000000, 32'h00000001,
                  32'h33000000, 32'h40000000, 32'h80000000, 32'h00000000, 32'h00800000, 32'h80800000};
        vec_s = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vec_r = '{32'h40000000, 32'h3E800000, 32'h00000000, 32'hBF800000, 32'h3F800000,
                  32'h3F800000, 32'h40400000, 32'h80000000, 32'h80000000, 32'h00000000, 32'h80000000};
        for (int i = 0; i < 11; i++) begin
            run_op(vec_a[i], vec_b[i], vec_s[i], r, o, v, lat);
            checks++;
            if (r !== vec_r[i] || o !== 1'b0 || v !== 1'b0) begin
                errors++;
                $display("FAIL arith[%0d] got %h ovf=%b inv=%b want %h ovf=0 inv=0", i, r, o, v, vec_r[i]);
            end
            checks++;
            if (lat !== 5) begin
                errors++; $display("FAIL latency[%0d] got %0d want 5", i, lat);
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] r; logic o, v; int lat;
        run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, r, o, v, lat);
        checks++;
        if (r !== 32'h7F800000 || o !== 1'b1 || v !== 1'b0 || lat !== 5) begin
            errors++; $display("FAIL overflow got %h ovf=%b inv=%b lat=%0d want 7f800000 1 0 5", r, o, v, lat);
        end
        run_op(32'h7F800000, 32'hFF800000, 1'b0, r, o, v, lat);
        checks++;
        if (r !== 32'h7FC00000 || o !== 1'b0 || v !== 1'b1 || lat !== 5) begin
            errors++; $display("FAIL inf_minus_inf got %h ovf=%b inv=%b lat=%0d want 7fc00000 0 1 5", r, o, v, lat);
        end
        run_op(32'h3F800000, 32'h7FC00001, 1'b0, r, o, v, lat);
        checks++;
        if (r !== 32'h7FC00000 || v !== 1'b1 || lat !== 5) begin
            errors++; $display("FAIL nan_in got %h inv=%b lat=%0d want 7fc00000 1 5", r, v, lat);
        end
        run_op(32'h3F800000, 32'h7F800000, 1'b1, r, o, v, lat);
        checks++;
        if (r !== 32'hFF800000 || o !== 1'b0 || v !== 1'b0) begin
            errors++; $display("FAIL single_inf got %h ovf=%b inv=%b want ff800000 0 0", r, o, v);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] hold;
        int n;
        a = 32'h3F800000; b = 32'h3F800000; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 32'h40000000; b = 32'h40000000;  // still offered, must be ignored while busy
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL busy_flags got ready=%b busy=%b want 0 1", in_ready, busy);
        end
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        in_valid = 1'b0;
        checks++;
        if (n !== 5) begin
            errors++; $display("FAIL bp_latency got %0d want 5", n);
        end
        hold = result;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h40000000 || flag_ovf !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%b rdy=%b res=%h want 1 0 40000000", i, out_valid, in_ready, result);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || hold !== 32'h40000000) begin
            errors++; $display("FAIL bp_release got v=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; logic o, v; int lat;
        run_op(32'h3F800000, 32'h3F800000, 1'b0, r, o, v, lat);
        run_op(32'h3FC00000, 32'h3FA00000, 1'b1, r, o, v, lat);
        checks++;
        if (r !== 32'h3E800000 || lat !== 5) begin
            errors++; $display("FAIL back_to_back got %h lat=%0d want 3e800000 5", r, lat);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] r; logic o, v; int lat;
        a = 32'h3F800000; b = 32'h3F800000; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);  // now in NORM
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || result !== 32'h0) begin
            errors++; $display("FAIL reset_mid got v=%b rdy=%b busy=%b res=%h want 0 1 0 0", out_valid, in_ready, busy, result);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_after got v=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        run_op(32'h3F800000, 32'h40000000, 1'b0, r, o, v, lat);
        checks++;
        if (r !== 32'h40400000 || lat !== 5) begin
            errors++; $display("FAIL fresh_op got %h lat=%0d want 40400000 5", r, lat);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        test_arith();
        test_specials();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
